// File: rtl/guard_recovery_ctrl_pkg.sv
// Shared guard types: recovery sequencer states, recovery cause record and
// the WAIT_ACK clear re-pulse interval.
package guard_recovery_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISOLATE,
    ST_RESET,
    ST_SETTLE,
    ST_CLEAR,
    ST_WAIT_ACK
  } recov_state_e;

  typedef struct packed {
    logic wr;
    logic rd;
  } cause_t;

  localparam int unsigned ClearRetryCycles = 4;

endpackage

// File: rtl/guard_recovery_ctrl_if.sv
// Signal bundle between the read/write guards, the slave isolator, the config
// registers and the recovery sequencer.
interface guard_recovery_ctrl_if #(
  parameter int unsigned RstCntWidth = 8,
  parameter int unsigned EvtCntWidth = 16
);
  import guard_recovery_ctrl_pkg::*;

  logic                   rd_reset_req_i;
  logic                   wr_reset_req_i;
  logic                   isolated_i;
  logic [RstCntWidth-1:0] rst_hold_i;
  logic                   irq_en_i;
  logic                   irq_clr_i;
  logic                   isolate_o;
  logic                   slv_rst_no;
  logic                   reset_clear_o;
  logic                   busy_o;
  cause_t                 cause_o;
  logic                   iso_timeout_o;
  logic [EvtCntWidth-1:0] evt_cnt_o;
  logic                   irq_o;
  recov_state_e           state_o;

  // isolate_o/isolated_i are a level request/ack pair: isolate_o stays high for
  // the whole recovery, isolated_i is only looked at while waiting for isolation,
  // and reset requests are held until reset_clear_o has been seen.
  modport slave (
    input  rd_reset_req_i, wr_reset_req_i, isolated_i, rst_hold_i, irq_en_i, irq_clr_i,
    output isolate_o, slv_rst_no, reset_clear_o, busy_o, cause_o, iso_timeout_o,
           evt_cnt_o, irq_o, state_o
  );

  modport master (
    output rd_reset_req_i, wr_reset_req_i, isolated_i, rst_hold_i, irq_en_i, irq_clr_i,
    input  isolate_o, slv_rst_no, reset_clear_o, busy_o, cause_o, iso_timeout_o,
           evt_cnt_o, irq_o, state_o
  );

endinterface

// File: rtl/guard_recovery_ctrl_sat_counter.sv
// Saturating increment counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] r_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= '0;
    end else if (inc_i && (r_q != '1)) begin
      r_q <= r_q + Width'(1);
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/guard_recovery_ctrl.sv
// Slave recovery sequencer: isolate, reset for a programmed hold, settle, then
// clear the guards; records cause, counts recoveries and raises a sticky irq.
module guard_recovery_ctrl
  import guard_recovery_ctrl_pkg::*;
#(
  parameter int unsigned RstCntWidth  = 8,
  parameter int unsigned IsoTimeout   = 256,
  parameter int unsigned SettleCycles = 4,
  parameter int unsigned EvtCntWidth  = 16
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  guard_recovery_ctrl_if.slave bus
);

  localparam int unsigned WaitW   = $clog2(IsoTimeout + 1);
  localparam int unsigned SettleW = $clog2(SettleCycles + 1);
  localparam int unsigned RetryW  = $clog2(ClearRetryCycles);

  recov_state_e           r_state;
  recov_state_e           w_next;
  logic [WaitW-1:0]       r_wait_cnt;
  logic [RstCntWidth-1:0] r_hold_cnt;
  logic [RstCntWidth-1:0] r_hold_tgt;
  logic [SettleW-1:0]     r_settle_cnt;
  logic [RetryW-1:0]      r_retry_cnt;
  logic                   r_busy;
  logic                   r_slv_rst_n;
  logic                   r_clear;
  cause_t                 r_cause;
  logic                   r_iso_to;
  logic                   r_irq;
  cause_t                 w_req_bits;
  logic                   w_req;
  logic                   w_iso_to;
  logic                   w_done;
  logic [EvtCntWidth-1:0] w_evt_cnt;

  assign w_req_bits = '{wr: bus.wr_reset_req_i, rd: bus.rd_reset_req_i};
  assign w_req      = bus.rd_reset_req_i | bus.wr_reset_req_i;
  assign w_iso_to   = (r_wait_cnt == WaitW'(IsoTimeout - 1));
  assign w_done     = (r_state == ST_WAIT_ACK) && !w_req;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_req) w_next = ST_ISOLATE;
      ST_ISOLATE:  if (bus.isolated_i || w_iso_to) w_next = ST_RESET;
      ST_RESET:    if (r_hold_cnt == r_hold_tgt) w_next = ST_SETTLE;
      ST_SETTLE:   if (r_settle_cnt == SettleW'(SettleCycles - 1)) w_next = ST_CLEAR;
      ST_CLEAR:    w_next = ST_WAIT_ACK;
      // Guards still requesting after the retry interval get another clear pulse.
      ST_WAIT_ACK: begin
        if (!w_req) w_next = ST_IDLE;
        else if (r_retry_cnt == RetryW'(ClearRetryCycles - 2)) w_next = ST_CLEAR;
      end
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_wait_cnt   <= '0;
      r_hold_cnt   <= '0;
      r_hold_tgt   <= '0;
      r_settle_cnt <= '0;
      r_retry_cnt  <= '0;
    end else begin
      r_state      <= w_next;
      r_wait_cnt   <= (r_state == ST_ISOLATE && w_next == ST_ISOLATE) ? r_wait_cnt + WaitW'(1) : '0;
      r_hold_cnt   <= (r_state == ST_RESET && w_next == ST_RESET) ? r_hold_cnt + RstCntWidth'(1) : '0;
      r_settle_cnt <= (r_state == ST_SETTLE && w_next == ST_SETTLE) ? r_settle_cnt + SettleW'(1) : '0;
      r_retry_cnt  <= (r_state == ST_WAIT_ACK && w_next == ST_WAIT_ACK) ? r_retry_cnt + RetryW'(1) : '0;
      // Hold length is frozen on entry; a programmed 0 behaves as 1.
      if (r_state != ST_RESET && w_next == ST_RESET) begin
        r_hold_tgt <= (bus.rst_hold_i == '0) ? '0 : bus.rst_hold_i - RstCntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy      <= 1'b0;
      r_slv_rst_n <= 1'b1;
      r_clear     <= 1'b0;
      r_cause     <= '0;
      r_iso_to    <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_busy      <= (w_next != ST_IDLE);
      r_slv_rst_n <= (w_next != ST_RESET);
      r_clear     <= (w_next == ST_CLEAR);
      if (r_state == ST_IDLE) begin
        if (w_req) r_cause <= w_req_bits;
      end else begin
        r_cause <= cause_t'(r_cause | w_req_bits);
      end
      if (r_state == ST_IDLE && w_req) begin
        r_iso_to <= 1'b0;
      end else if (r_state == ST_ISOLATE && !bus.isolated_i && w_iso_to) begin
        r_iso_to <= 1'b1;
      end
      if (w_done && bus.irq_en_i) r_irq <= 1'b1;
      else if (bus.irq_clr_i)     r_irq <= 1'b0;
    end
  end

  sat_counter #(
    .Width (EvtCntWidth)
  ) u_evt_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (w_done),
    .q_o    (w_evt_cnt)
  );

  assign bus.isolate_o     = r_busy;
  assign bus.busy_o        = r_busy;
  assign bus.slv_rst_no    = r_slv_rst_n;
  assign bus.reset_clear_o = r_clear;
  assign bus.cause_o       = r_cause;
  assign bus.iso_timeout_o = r_iso_to;
  assign bus.evt_cnt_o     = w_evt_cnt;
  assign bus.irq_o         = r_irq;
  assign bus.state_o       = r_state;

endmodule
